// File: rtl/nios_mul_seq_pkg.sv
// rtl/nios_mul_seq_pkg.sv - shared op encodings, state enum and width for the multiply sequencer
package nios_mul_seq_pkg;

    localparam int MUL_W = 32;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULXUU = 2'b01;
    localparam logic [1:0] MUL_OP_MULXSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULXSS = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_LO = 3'd1,
        ST_WAIT_LO  = 3'd2,
        ST_ISSUE_HI = 3'd3,
        ST_WAIT_HI  = 3'd4,
        ST_DONE     = 3'd5
    } mul_state_e;

endpackage

// File: rtl/nios_mul_seq.sv
// rtl/nios_mul_seq.sv - multi-cycle multiply sequencer driving a 3-product 16x16 multiplier cell
module nios_mul_seq
    import nios_mul_seq_pkg::*;
#(
    parameter int CELL_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [MUL_W-1:0] req_src1,
    input  logic [MUL_W-1:0] req_src2,
    input  logic             cancel,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [MUL_W-1:0] resp_result,
    output logic [MUL_W-1:0] mul_src1,
    output logic [MUL_W-1:0] mul_src2,
    output logic             mul_en,
    input  logic [MUL_W-1:0] mul_cell_p1,
    input  logic [MUL_W-1:0] mul_cell_p2,
    input  logic [MUL_W-1:0] mul_cell_p3
);

    localparam logic [1:0] CNT_LOAD = 2'(CELL_LATENCY - 1);

    mul_state_e         r_state;
    mul_state_e         w_state_nxt;
    logic [1:0]         r_op;
    logic [MUL_W-1:0]   r_a;
    logic [MUL_W-1:0]   r_b;
    logic [2*MUL_W-1:0] r_acc;
    logic [2*MUL_W-1:0] w_acc_nxt;
    logic [1:0]         r_cnt;
    logic [MUL_W-1:0]   r_src1;
    logic [MUL_W-1:0]   r_src2;
    logic [MUL_W-1:0]   r_result;
    logic               r_en;

    logic [MUL_W:0]     w_cross;
    logic               w_a_signed;
    logic [2*MUL_W-1:0] w_corr_a;
    logic [2*MUL_W-1:0] w_corr_b;

    // Cross terms summed at 33 bits so their carry reaches bit 48 of the product
    assign w_cross    = {1'b0, mul_cell_p2} + {1'b0, mul_cell_p3};
    assign w_a_signed = (r_op == MUL_OP_MULXSU) || (r_op == MUL_OP_MULXSS);
    assign w_corr_b   = (w_a_signed && r_a[MUL_W-1]) ? {r_b, {MUL_W{1'b0}}} : '0;
    assign w_corr_a   = ((r_op == MUL_OP_MULXSS) && r_b[MUL_W-1]) ? {r_a, {MUL_W{1'b0}}} : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = ST_ISSUE_LO;
                    w_acc_nxt   = '0;
                end
            end
            ST_ISSUE_LO: w_state_nxt = ST_WAIT_LO;
            ST_WAIT_LO: begin
                if (r_cnt == 2'd0) begin
                    w_acc_nxt   = r_acc + {{MUL_W{1'b0}}, mul_cell_p1}
                                        + {15'b0, w_cross, 16'b0};
                    w_state_nxt = (r_op == MUL_OP_MUL) ? ST_DONE : ST_ISSUE_HI;
                end
            end
            ST_ISSUE_HI: w_state_nxt = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (r_cnt == 2'd0) begin
                    w_acc_nxt   = r_acc + {mul_cell_p1, {MUL_W{1'b0}}} - w_corr_b - w_corr_a;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (resp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (cancel) begin
            w_state_nxt = ST_IDLE;
            w_acc_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_src1   <= '0;
            r_src2   <= '0;
            r_result <= '0;
            r_en     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_en    <= (w_state_nxt == ST_ISSUE_LO) || (w_state_nxt == ST_ISSUE_HI);

            if (r_state == ST_IDLE && w_state_nxt == ST_ISSUE_LO) begin
                r_op   <= req_op;
                r_a    <= req_src1;
                r_b    <= req_src2;
                r_src1 <= req_src1;
                r_src2 <= req_src2;
            end
            if (r_state == ST_WAIT_LO && w_state_nxt == ST_ISSUE_HI) begin
                r_src1 <= {16'h0, r_a[MUL_W-1:16]};
                r_src2 <= {16'h0, r_b[MUL_W-1:16]};
            end

            if (r_state == ST_ISSUE_LO || r_state == ST_ISSUE_HI) begin
                r_cnt <= CNT_LOAD;
            end else if ((r_state == ST_WAIT_LO || r_state == ST_WAIT_HI) && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end

            // Result is frozen on entry to DONE so the response never sees cell inputs
            if (cancel) begin
                r_result <= '0;
            end else if (w_state_nxt == ST_DONE && r_state != ST_DONE) begin
                r_result <= (r_op == MUL_OP_MUL) ? w_acc_nxt[MUL_W-1:0] : w_acc_nxt[2*MUL_W-1:MUL_W];
            end
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign resp_valid  = (r_state == ST_DONE);
    assign resp_result = r_result;
    assign mul_src1    = r_src1;
    assign mul_src2    = r_src2;
    assign mul_en      = r_en;

endmodule

// File: tb/tb_nios_mul_seq.sv
// tb/tb_nios_mul_seq.sv - bench for nios_mul_seq at cell latencies 1 and 3
module tb_nios_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n       [2];
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [1:0]  req_op      [2];
    logic [31:0] req_src1    [2];
    logic [31:0] req_src2    [2];
    logic        cancel      [2];
    logic        resp_valid  [2];
    logic        resp_ready  [2];
    logic [31:0] resp_result [2];
    logic [31:0] mul_src1    [2];
    logic [31:0] mul_src2    [2];
    logic        mul_en      [2];
    logic [31:0] cell_p1     [2];
    logic [31:0] cell_p2     [2];
    logic [31:0] cell_p3     [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] pp1 [3];
        logic [31:0] pp2 [3];
        logic [31:0] pp3 [3];

        nios_mul_seq #(.CELL_LATENCY(LAT)) u_dut (
            .clk(clk), .reset_n(rst_n[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_op(req_op[g]),
            .req_src1(req_src1[g]), .req_src2(req_src2[g]), .cancel(cancel[g]),
            .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]), .resp_result(resp_result[g]),
            .mul_src1(mul_src1[g]), .mul_src2(mul_src2[g]), .mul_en(mul_en[g]),
            .mul_cell_p1(cell_p1[g]), .mul_cell_p2(cell_p2[g]), .mul_cell_p3(cell_p3[g])
        );

        // Behavioural cell: unsigned 16x16 products, LAT cycles after the enable cycle
        always @(posedge clk) begin
            if (mul_en[g]) begin
                pp1[0] <= 32'(mul_src1[g][15:0]) * 32'(mul_src2[g][15:0]);
                pp2[0] <= 32'(mul_src1[g][15:0]) * 32'(mul_src2[g][31:16]);
                pp3[0] <= 32'(mul_src1[g][31:16]) * 32'(mul_src2[g][15:0]);
            end
            for (int k = 1; k < 3; k++) begin
                pp1[k] <= pp1[k-1];
                pp2[k] <= pp2[k-1];
                pp3[k] <= pp3[k-1];
            end
        end
        assign cell_p1[g] = pp1[LAT-1];
        assign cell_p2[g] = pp2[LAT-1];
        assign cell_p3[g] = pp3[LAT-1];
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = {32'b0, a};
        xb = {32'b0, b};
        if (op == 2'b10 || op == 2'b11) xa = {{32{a[31]}}, a};
        if (op == 2'b11) xb = {{32{b[31]}}, b};
        p = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic do_op(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic [31:0] exp_res, input string name);
        int cyc, en, guard, exp_cyc;
        logic got;
        exp_cyc = (op == 2'b00) ? 2 + lat_of(d) : 3 + 2 * lat_of(d);
        @(negedge clk);
        req_valid[d] = 1'b1; req_op[d] = op; req_src1[d] = a; req_src2[d] = b;
        guard = 0;
        while (!req_ready[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (!req_ready[d]) begin
            n_fail++;
            $display("FAIL %s[d%0d] accept: req_ready=%0b required 1", name, d, req_ready[d]);
        end
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        cyc = 0; en = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mul_en[d]) en++;
            if (resp_valid[d]) got = 1'b1;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s[d%0d] timeout: no resp_valid after %0d cycles", name, d, cyc);
            return;
        end
        if (resp_result[d] !== exp_res) begin
            n_fail++;
            $display("FAIL %s[d%0d] result: got %h required %h", name, d, resp_result[d], exp_res);
        end
        n_tests++;
        if (cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL %s[d%0d] latency: got cycle %0d required %0d", name, d, cyc, exp_cyc);
        end
        n_tests++;
        if (en != ((op == 2'b00) ? 1 : 2)) begin
            n_fail++;
            $display("FAIL %s[d%0d] mul_en pulses: got %0d required %0d", name, d, en, (op == 2'b00) ? 1 : 2);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_tests++;
            if (resp_valid[d] !== 1'b1 || resp_result[d] !== exp_res || req_ready[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s[d%0d] hold %0d: valid=%0b result=%h req_ready=%0b required 1/%h/0",
                         name, d, i, resp_valid[d], resp_result[d], req_ready[d], exp_res);
            end
        end
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1 resp_ready[d] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s[d%0d] after handshake: valid=%0b req_ready=%0b required 0/1",
                     name, d, resp_valid[d], req_ready[d]);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) rst_n[d] = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (resp_valid[d] !== 1'b0 || resp_result[d] !== 32'h0 || mul_en[d] !== 1'b0 ||
                mul_src1[d] !== 32'h0 || mul_src2[d] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset[d%0d]: valid=%0b result=%h en=%0b src1=%h src2=%h required all 0",
                         d, resp_valid[d], resp_result[d], mul_en[d], mul_src1[d], mul_src2[d]);
            end
        end
        for (int d = 0; d < 2; d++) rst_n[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (req_ready[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready[d%0d]: req_ready=%0b required 1", d, req_ready[d]);
            end
        end
    endtask

    task automatic test_all_ones(input int d);
        do_op(d, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0001, "ones_mul");
        do_op(d, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, "ones_mulxuu");
        do_op(d, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, "ones_mulxsu");
        do_op(d, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0000, "ones_mulxss");
    endtask

    task automatic test_carry(input int d);
        do_op(d, 2'b00, 32'h0001_0000, 32'h0001_0000, 0, 32'h0000_0000, "carry_mul");
        do_op(d, 2'b01, 32'h0001_0000, 32'h0001_0000, 0, 32'h0000_0001, "carry_mulxuu");
        do_op(d, 2'b01, 32'h0000_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_FFFE, "carry_cross");
    endtask

    task automatic test_backpressure(input int d);
        do_op(d, 2'b11, 32'h8000_0000, 32'h0000_0002, 4, 32'hFFFF_FFFF, "backpressure");
    endtask

    task automatic test_cancel(input int d);
        int bad;
        @(negedge clk);
        req_valid[d] = 1'b1; req_op[d] = 2'b11; req_src1[d] = 32'hFFFF_FFFF; req_src2[d] = 32'h1234_5678;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        for (int c = 1; c <= lat_of(d) + 3; c++) @(negedge clk);
        cancel[d] = 1'b1;
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1 cancel[d] = 1'b0;
        resp_ready[d] = 1'b0;
        bad = 0;
        for (int c = 0; c < 2 * lat_of(d) + 4; c++) begin
            @(negedge clk);
            if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL cancel[d%0d]: %0d cycles with resp_valid or !req_ready, required 0", d, bad);
        end
        do_op(d, 2'b00, 32'd3, 32'd5, 0, 32'h0000_000F, "after_cancel");
    endtask

    task automatic test_reset_mid(input int d);
        @(negedge clk);
        req_valid[d] = 1'b1; req_op[d] = 2'b01; req_src1[d] = 32'hDEAD_BEEF; req_src2[d] = 32'hCAFE_F00D;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n[d] = 1'b0;
        #1;
        n_tests++;
        if (resp_valid[d] !== 1'b0 || resp_result[d] !== 32'h0 || mul_en[d] !== 1'b0 ||
            mul_src1[d] !== 32'h0 || mul_src2[d] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid[d%0d]: valid=%0b result=%h en=%0b src1=%h src2=%h required all 0",
                     d, resp_valid[d], resp_result[d], mul_en[d], mul_src1[d], mul_src2[d]);
        end
        repeat (2) @(negedge clk);
        rst_n[d] = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release[d%0d]: req_ready=%0b valid=%0b required 1/0",
                     d, req_ready[d], resp_valid[d]);
        end
        do_op(d, 2'b10, 32'hFFFF_FFFE, 32'd7, 0, model(2'b10, 32'hFFFF_FFFE, 32'd7), "after_reset");
    endtask

    task automatic test_back_to_back(input int d);
        logic [31:0] a, b;
        logic [1:0]  op;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       begin a = 32'h8000_0000 | $urandom; b = $urandom; end
                1:       begin a = $urandom; b = 32'h8000_0000 | $urandom; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            do_op(d, op, a, b, $urandom_range(0, 2), model(op, a, b), "random");
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_op[d] = 2'b00;
            req_src1[d] = 32'h0; req_src2[d] = 32'h0; cancel[d] = 1'b0; resp_ready[d] = 1'b0;
        end
        test_reset();
        for (int d = 0; d < 2; d++) begin
            test_all_ones(d);
            test_carry(d);
            test_backpressure(d);
            test_cancel(d);
            test_reset_mid(d);
            test_back_to_back(d);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_mul_seq.md
# nios_mul_seq

Multi-cycle multiply sequencer that issues operands to the CPU's 3-product 16x16 multiplier cell and assembles the cell's registered partial products into a 32-bit result. It sits between the execute stage and the multiplier cell, on the consumer side of that cell. It supports the Nios II `mul`, `mulxuu`, `mulxsu` and `mulxss` operations. A request/response valid-ready handshake lets the pipeline stall on it.

## Interface
Parameters:
- CELL_LATENCY, 1, clock cycles from a cycle with `mul_en`=1 to valid `mul_cell_p*`. Legal range is 1..3.

Ports:
- clk  in  1  system clock; every register is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  2  operation: 00 MUL (low word), 01 MULXUU, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXSS.
- req_src1  in  32  operand A.
- req_src2  in  32  operand B.
- cancel  in  1  synchronous abort; drops any in-flight operation.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_result  out  32  low word of the product (MUL) or high word (MULX*).
- mul_src1  out  32  cell operand 1.
- mul_src2  out  32  cell operand 2.
- mul_en  out  1  cell clock enable.
- mul_cell_p1  in  32  partial product src1[15:0]*src2[15:0].
- mul_cell_p2  in  32  partial product src1[15:0]*src2[31:16].
- mul_cell_p3  in  32  partial product src1[31:16]*src2[15:0].

## Operation
- **States:** IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, DONE.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`: latch op, A and B, clear the 64-bit accumulator, go to ISSUE_LO.
- **ISSUE_LO:**
  - Drive `mul_src1`=A and `mul_src2`=B, with `mul_en`=1 for exactly one cycle.
  - Load the wait counter with CELL_LATENCY-1 and go to WAIT_LO.
- **WAIT_LO:**
  - Decrement the counter.
  - When the counter is 0, add p1 + ((p2+p3)<<16) into the accumulator. The p2+p3 sum is 33 bits wide and must not be truncated.
  - Then go to DONE if op is MUL, otherwise go to ISSUE_HI.
- **ISSUE_HI:**
  - Drive `mul_src1`={16'h0, A[31:16]} and `mul_src2`={16'h0, B[31:16]}, with `mul_en`=1.
  - Go to WAIT_HI.
- **WAIT_HI:**
  - When the counter is 0, add p1<<32 to the accumulator.
  - Apply signed corrections, all in arithmetic mod 2^64:
    - Subtract B<<32 if A is signed (op 10 or 11) and A[31]=1.
    - Subtract A<<32 if op is 11 and B[31]=1.
  - Go to DONE.
- **DONE:**
  - `resp_valid`=1.
  - `resp_result` = acc[31:0] for MUL, acc[63:32] otherwise.
  - Hold state and output until `resp_ready`, then go to IDLE.
- **Operand outputs when not issuing:** `mul_src*` hold their last value and `mul_en`=0.
- **cancel:**
  - In any state, the next state is IDLE, `resp_valid` drops and the accumulator is cleared.
  - `cancel` has priority over `req_valid` and `resp_ready` in the same cycle.
  - A cell output arriving after a cancel is ignored.
- **Reset:** all state and outputs go to 0 and the FSM goes to IDLE, so `req_ready`=1 the first cycle after reset release. Reset mid-operation discards the operation.

## Timing
- With CELL_LATENCY=1 and the request accepted at cycle 0:
  - MUL: `resp_valid` at cycle 3.
  - MULX*: `resp_valid` at cycle 5.
- Each extra cycle of CELL_LATENCY adds 1 cycle per pass.
- There is no combinational path from `req_*` or `mul_cell_*` to `resp_*`. `resp_result` comes straight from a register.
- Back-to-back requests: the earliest next accept is the cycle after the DONE handshake.
- `req_ready` is a function of state only and does not depend on `req_valid`.

## Structure
- Shared package holds:
  - op encodings `MUL_OP_MUL`, `MUL_OP_MULXUU`, `MUL_OP_MULXSU`, `MUL_OP_MULXSS`;
  - the state enum;
  - the width constant 32.
- No sub-module is needed. The sequencer is a single FSM with a wait counter and a 64-bit accumulator.
- The multiplier cell is instantiated by the parent, not inside this block.
- The bench pairs this block with a behavioural cell model with parameterised latency.

## Test plan
- MUL with A=B=0xFFFFFFFF → result 0x00000001 at cycle 3. Exactly one `mul_en` pulse.
- Same operands, MULXUU → 0xFFFFFFFE; MULXSU → 0xFFFFFFFF; MULXSS → 0x00000000. `resp_valid` at cycle 5, with two `mul_en` pulses.
- A=0x00010000, B=0x00010000: MUL → 0x00000000; MULXUU → 0x00000001. This checks the 33-bit cross-term carry.
- A=0x80000000, B=0x00000002, MULXSS → 0xFFFFFFFF. Hold `resp_ready`=0 for 4 cycles; result stays stable and `req_ready`=0 throughout.
- Assert `cancel` during WAIT_HI of a MULXSS, then issue MUL with A=3, B=5 → 0x0000000F. No stale result is emitted. Also assert `reset_n`=0 mid-WAIT_LO → all outputs are 0 immediately.
- Repeat all cases with CELL_LATENCY=3 → MUL at cycle 5, MULX* at cycle 9, identical results.
